// File: rtl/mm_skew_feeder.sv
// ---------------------------------------------------------------------------
// mm_skew_feeder
//
// Upstream feeder for an NxN output-stationary systolic matrix-multiply array.
// Each accepted beat is one k-slice: column k of A (one element per array row)
// and row k of B (one element per array column). The slice is skewed
// diagonally onto the left-edge row lanes and top-edge column lanes. Lane i is
// delayed by i+1 cycles, so PE(r,c) sees A[r][k] and B[k][c] in the same cycle.
// The block also issues a one-cycle accumulator flush before each job, pads
// the lanes with zeros while the wavefront drains, and pulses done_o once
// every PE result is final.
//
// Optional feature (build macro MM_FEED_PERF_EN):
//   Adds the stall_cnt output. It counts FEED cycles that have in_valid low.
//   The counter is cleared on reset and in FLUSH, and it saturates at 16'hFFFF.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset (aborts any job in flight)
//   start      begin a job; sampled only when idle
//   k_len      number of k-slices in the job (0..K_MAX), latched on start
//   in_valid   slice beat valid
//   in_ready   beat accepted this cycle when high (FEED only)
//   a_vec      a_vec[i*DW+:DW] = A[i][k]
//   b_vec      b_vec[j*DW+:DW] = B[k][j]
//   row_o      row lane i -> PE(i,0)
//   col_o      column lane j -> PE(0,j)
//   flush_o    clears all PE accumulators and pipeline registers
//   busy_o     a job is in progress
//   done_o     one-cycle pulse: all N*N results final
//   stall_cnt  (MM_FEED_PERF_EN only) FEED cycles without a valid beat
// ---------------------------------------------------------------------------
module mm_skew_feeder #(
   parameter int N     = 4,
   parameter int DW    = 8,
   parameter int K_MAX = 64,
   localparam int KW   = $clog2(K_MAX + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [KW-1:0]   k_len,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] a_vec,
   input  logic [N*DW-1:0] b_vec,
   output logic [N*DW-1:0] row_o,
   output logic [N*DW-1:0] col_o,
   output logic            flush_o,
   output logic            busy_o,
   output logic            done_o
`ifdef MM_FEED_PERF_EN
   ,
   output logic [15:0]     stall_cnt
`endif
);

   // The drain phase covers 2N-1 cycles: the last beat needs N cycles to
   // reach the far lane, and then N-1 more cycles to cross the array.
   localparam int DCW = (2 * N > 2) ? $clog2(2 * N) : 1;
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * N - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [KW-1:0]   k_lat;
   logic [KW-1:0]   beat_cnt;
   logic [KW-1:0]   beat_nxt;
   logic [DCW-1:0]  drain_cnt;
   logic            hs;

   assign hs       = in_valid & in_ready;
   assign beat_nxt = beat_cnt + KW'(1);

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      flush_o   = 1'b0;
      done_o    = 1'b0;
      busy_o    = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            flush_o   = 1'b1;
            state_nxt = (k_lat == '0) ? S_DONE : S_FEED;
         end
         S_FEED: begin
            in_ready = 1'b1;
            if (in_valid && (beat_nxt == k_lat)) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done_o    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k_lat     <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if ((state == S_IDLE) && start) begin
            k_lat <= k_len;
         end
         if (state == S_FLUSH) begin
            beat_cnt <= '0;
         end else if (hs) begin
            beat_cnt <= beat_nxt;
         end
         if (state == S_DRAIN) begin
            drain_cnt <= drain_cnt + DCW'(1);
         end else begin
            drain_cnt <= '0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Skew chains: lane i is i+1 registers deep. Any cycle without a handshake
   // injects a zero wavefront. This keeps the diagonal alignment through
   // bubbles, and it also gives the zero padding during drain and idle.
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] row_p [i+1];
      logic [DW-1:0] col_p [i+1];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int s = 0; s <= i; s++) begin
               row_p[s] <= '0;
               col_p[s] <= '0;
            end
         end else begin
            row_p[0] <= hs ? a_vec[i*DW +: DW] : '0;
            col_p[0] <= hs ? b_vec[i*DW +: DW] : '0;
            for (int s = 1; s <= i; s++) begin
               row_p[s] <= row_p[s-1];
               col_p[s] <= col_p[s-1];
            end
         end
      end

      assign row_o[i*DW +: DW] = row_p[i];
      assign col_o[i*DW +: DW] = col_p[i];
   end

`ifdef MM_FEED_PERF_EN
   // ------------------------------------------------------------------------
   // Stall counter: holds its value after the job ends, until the next FLUSH.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (state == S_FLUSH) begin
         stall_cnt <= '0;
      end else if ((state == S_FEED) && !in_valid && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mm_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_mm_skew_feeder
//
// Bench for mm_skew_feeder. The reference model works on cycle timestamps.
// It records each accepted beat and its cycle. From these records it derives
// the expected value of every lane, the flush and done cycles, and the
// in_ready and busy windows. Array results are rebuilt from the observed lane
// history, the way an output-stationary array would consume the lanes. They
// are then compared with a plain A*B sum. Build with +define+MM_FEED_PERF_EN
// to also check stall_cnt.
// ---------------------------------------------------------------------------
module tb_mm_skew_feeder;
   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int K_MAX = 64;
   localparam int KW    = $clog2(K_MAX + 1);
   localparam int MAXC  = 20000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] a_vec;
   logic [N*DW-1:0] b_vec;
   logic [N*DW-1:0] row_o;
   logic [N*DW-1:0] col_o;
   logic            flush_o;
   logic            busy_o;
   logic            done_o;
`ifdef MM_FEED_PERF_EN
   logic [15:0]     stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   mm_skew_feeder #(.N(N), .DW(DW), .K_MAX(K_MAX)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .k_len    (k_len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_vec    (a_vec),
      .b_vec    (b_vec),
      .row_o    (row_o),
      .col_o    (col_o),
      .flush_o  (flush_o),
      .busy_o   (busy_o),
      .done_o   (done_o)
`ifdef MM_FEED_PERF_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   // ---------------- reference model state ----------------
   bit              chk_en   = 1'b0;
   bit              job      = 1'b0;
   int              s_cyc    = -100;
   int              klen_m   = 0;
   int              beats_m  = 0;
   int              done_cyc = -1;
   int              last_rst = -1;
   int              last_done = -100;
   int              stall_m  = 0;
   bit              hs_ok [MAXC];
   logic [N*DW-1:0] hs_a  [MAXC];
   logic [N*DW-1:0] hs_b  [MAXC];
   logic [N*DW-1:0] rh    [MAXC];
   logic [N*DW-1:0] ch    [MAXC];
   longint          refm  [N][N];

   // PE(r,c) sees row lane r delayed by c cycles and column lane c delayed
   // by r cycles. The sum is taken from the flush cycle up to the cycle
   // before done.
   task automatic check_result(input int tdone);
      longint sum;
      int ir, ic;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            sum = 0;
            for (int tt = s_cyc + 1; tt < tdone; tt++) begin
               ir = tt - c;
               ic = tt - r;
               if (ir >= 0 && ic >= 0)
                  sum += longint'(rh[ir][r*DW +: DW]) * longint'(ch[ic][c*DW +: DW]);
            end
            check($sformatf("res[%0d][%0d]", r, c), sum, refm[r][c]);
         end
      end
   endtask

   always @(negedge clk) begin
      int t, h;
      logic [N*DW-1:0] er, ec;
      bit eb, ef, ed, erdy;
      t = cyc;
      erdy = 1'b0;
      if (t < MAXC) begin
         if (chk_en) begin
            eb   = job && (t > s_cyc) && (done_cyc < 0 || t <= done_cyc);
            ef   = job && (t == s_cyc + 1);
            ed   = job && (t == done_cyc);
            erdy = job && (klen_m > 0) && (t >= s_cyc + 2) && (beats_m < klen_m);
            for (int i = 0; i < N; i++) begin
               h = t - i - 1;
               if (h > last_rst && h >= 0 && hs_ok[h]) begin
                  er[i*DW +: DW] = hs_a[h][i*DW +: DW];
                  ec[i*DW +: DW] = hs_b[h][i*DW +: DW];
               end else begin
                  er[i*DW +: DW] = '0;
                  ec[i*DW +: DW] = '0;
               end
            end
            check("busy_o", busy_o, eb);
            check("flush_o", flush_o, ef);
            check("done_o", done_o, ed);
            check("in_ready", in_ready, erdy);
            check("row_o", row_o, er);
            check("col_o", col_o, ec);
            if (ed) check_result(t);
`ifdef MM_FEED_PERF_EN
            if (t == last_done + 1) check("stall_cnt", stall_cnt, stall_m);
`endif
         end
         rh[t] = row_o;
         ch[t] = col_o;
         if (!rst_n) begin
            job      = 1'b0;
            last_rst = t;
            chk_en   = 1'b1;
         end else if (chk_en) begin
            if (erdy && in_valid) begin
               hs_ok[t] = 1'b1;
               hs_a[t]  = a_vec;
               hs_b[t]  = b_vec;
               beats_m++;
               for (int r = 0; r < N; r++)
                  for (int c = 0; c < N; c++)
                     refm[r][c] += longint'(a_vec[r*DW +: DW]) * longint'(b_vec[c*DW +: DW]);
               if (beats_m == klen_m) done_cyc = t + 2 * N;
            end
            if (erdy && !in_valid && stall_m < 65535) stall_m++;
            if (job && t == done_cyc) begin
               job       = 1'b0;
               last_done = t;
            end else if (!job && start) begin
               job      = 1'b1;
               s_cyc    = t;
               klen_m   = int'(k_len);
               beats_m  = 0;
               stall_m  = 0;
               done_cyc = (k_len == '0) ? t + 2 : -1;
               for (int r = 0; r < N; r++)
                  for (int c = 0; c < N; c++)
                     refm[r][c] = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_beat(input int mode, input int bi, input int ca, input int cb);
      for (int i = 0; i < N; i++) begin
         case (mode)
            0: begin
               a_vec[i*DW +: DW] = (i == bi) ? 8'd1 : 8'd0;
               b_vec[i*DW +: DW] = (i == bi) ? 8'd1 : 8'd0;
            end
            1: begin
               a_vec[i*DW +: DW] = DW'(ca);
               b_vec[i*DW +: DW] = DW'(cb);
            end
            default: begin
               a_vec[i*DW +: DW] = DW'($urandom);
               b_vec[i*DW +: DW] = DW'($urandom);
            end
         endcase
      end
   endtask

   function automatic bit pick(input logic [63:0] vpat, input bit vrand, input int vi);
      if (vrand) return ($urandom_range(0, 2) != 0);
      if (vi < 64) return vpat[vi];
      return 1'b1;
   endfunction

   task automatic run_job(input int kl, input int mode, input int ca, input int cb,
                          input logic [63:0] vpat, input bit vrand, input bit poke);
      int bi, vi, guard;
      bit rdy, v, seen;
      start = 1'b1;
      k_len = KW'(kl);
      @(posedge clk); #1;
      start = 1'b0;
      k_len = KW'($urandom_range(0, K_MAX));
      bi = 0; vi = 0; guard = 0;
      set_beat(mode, bi, ca, cb);
      in_valid = (kl > 0) ? pick(vpat, vrand, vi) : 1'b0;
      while (bi < kl && guard < 1000) begin
         @(negedge clk);
         rdy = in_ready;
         v   = in_valid;
         @(posedge clk); #1;
         guard++;
         if (rdy) begin
            vi++;
            if (v) bi++;
         end
         start = poke && rdy && (bi == 2);
         set_beat(mode, bi, ca, cb);
         in_valid = (bi < kl) ? pick(vpat, vrand, vi) : 1'b0;
      end
      if (guard >= 1000) check("feed_timeout", 1, 0);
      in_valid = 1'b0;
      start    = poke;
      seen = 1'b0; guard = 0;
      while (!seen && guard < 300) begin
         @(negedge clk);
         seen = done_o;
         guard++;
         @(posedge clk); #1;
         start = 1'b0;
      end
      if (!seen) check("done_timeout", 1, 0);
   endtask

   initial begin
      #(MAXC * 10);
      $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
      $fatal(1);
   end

   initial begin
      int nh;
      rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; a_vec = '0; b_vec = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of FEED after two beats.
      start = 1'b1; k_len = KW'(8);
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      set_beat(2, 0, 0, 0);
      nh = 0;
      for (int g = 0; g < 50 && nh < 2; g++) begin
         @(negedge clk);
         if (in_ready && in_valid) nh++;
         @(posedge clk); #1;
         set_beat(2, 0, 0, 0);
      end
      rst_n = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      run_job(4, 0, 0, 0, {64{1'b1}}, 1'b0, 1'b0);                 // identity
      run_job(4, 1, 2, 3, 64'b110101, 1'b0, 1'b0);                 // bubbles
      run_job(64, 1, 255, 255, {64{1'b1}}, 1'b0, 1'b0);            // edge values
      run_job(0, 2, 0, 0, {64{1'b1}}, 1'b0, 1'b0);                 // empty job
      run_job(6, 2, 0, 0, {64{1'b1}}, 1'b0, 1'b1);                 // start pokes
      run_job(4, 1, 1, 1, 64'b1010101, 1'b0, 1'b0);                // 3 stalls
      for (int j = 0; j < 25; j++)
         run_job($urandom_range(0, 12), 2, 0, 0, '0, 1'b1, bit'($urandom_range(0, 1)));
      repeat (5) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
